cfgcnt: RTL and testbench
=========================

CFGCNT -- requirements
Module: cfgcnt

Interface
REQ-001 Parameter CNT_W, default 6, SHALL set the counter, bound, load and step width in bits (minimum 2).
REQ-002 Parameter RST_VAL, default 0, SHALL set the value o_cnt takes on reset.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rstn  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-005 i_en  input  1  SHALL be the count enable; count advances only while high.
REQ-006 i_clr  input  1  SHALL be the synchronous clear to 0.
REQ-007 i_load  input  1  SHALL be the synchronous load strobe.
REQ-008 i_load_val  input  CNT_W  SHALL be the value to load.
REQ-009 i_dir  input  1  SHALL select direction: 1 up, 0 down.
REQ-010 i_step  input  CNT_W  SHALL be the increment/decrement per enabled cycle.
REQ-011 i_bnd  input  CNT_W  SHALL be the runtime upper bound; the legal range is 0..i_bnd.
REQ-012 i_mode  input  2  SHALL select the mode: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-013 o_cnt  output  CNT_W  SHALL be the registered count.
REQ-014 o_tc  output  1  SHALL be a combinational terminal flag: (i_dir and o_cnt==i_bnd) or (!i_dir and o_cnt==0).
REQ-015 o_wrap  output  1  SHALL be a registered one-cycle pulse, high in the cycle after a wrap transition.
REQ-016 o_done  output  1  SHALL be the registered one-shot completion flag.

Function
REQ-017 Per-edge priority SHALL be: reset > i_clr > i_load > i_en; lower-priority requests in the same cycle are ignored.
REQ-018 i_clr SHALL set o_cnt=0, o_done=0 and o_wrap=0.
REQ-019 i_load SHALL set o_cnt=min(i_load_val, i_bnd), o_done=0 and o_wrap=0.
REQ-020 With i_en=0, or with i_en=1 and i_step=0, o_cnt and o_done SHALL hold and o_wrap SHALL be 0.
REQ-021 Next-value arithmetic SHALL use CNT_W+1 bits so that o_cnt+i_step never silently overflows.
REQ-022 Up, o_cnt<i_bnd: next=min(o_cnt+i_step, i_bnd) in every mode; the terminal value is always hit exactly, never skipped.
REQ-023 Up, o_cnt>=i_bnd in wrap mode: next=0 and o_wrap pulses.
REQ-024 Up, o_cnt>=i_bnd in saturate mode: next=i_bnd, with no pulse.
REQ-025 Down, o_cnt>0: next=max(o_cnt-i_step, 0) in every mode, computed without underflow.
REQ-026 Down, o_cnt==0 in wrap mode: next=i_bnd and o_wrap pulses.
REQ-027 Down, o_cnt==0 in saturate mode: next=0 (hold).
REQ-028 One-shot mode SHALL behave as saturate mode, and SHALL set o_done=1 on the edge where next equals the terminal value for the current i_dir.
REQ-029 o_done=1 SHALL freeze o_cnt against i_en; only i_clr, i_load or reset clear o_done.
REQ-030 If i_bnd is lowered below o_cnt, up counting SHALL follow REQ-023/024/028 (wrap mode goes to 0; saturate and one-shot clamp to i_bnd); down counting SHALL follow REQ-025 unchanged.
REQ-031 A change of i_dir or i_mode SHALL take effect on the next enabled edge without disturbing o_cnt.
REQ-032 With i_dir=1, i_mode=00, i_step=1 and i_bnd=K, the counter SHALL reproduce the sequence 0,1,..,K,0,...

Reset
REQ-033 i_rstn=0 at an edge SHALL force o_cnt=RST_VAL, o_wrap=0 and o_done=0, overriding all other inputs.
REQ-034 Reset asserted mid-count or in the one-shot done state SHALL take effect on that edge with no residual pulse.
REQ-035 After reset release, the first count SHALL occur on the first edge with i_en=1.

Verification
REQ-036 Wrap up: CNT_W=6, i_bnd=32, step 1, up, en held -> 0..32,0; o_wrap high exactly one cycle after the 32->0 edge; o_tc high while o_cnt=32.
REQ-037 Step clamp: i_bnd=10, step 4, up, wrap -> 0,4,8,10,0; down from 10 -> 6,2,0,10.
REQ-038 Saturate: i_bnd=5, step 3, up -> 0,3,5,5,5; o_wrap never asserted.
REQ-039 One-shot down: load 7, step 2 -> 5,3,1,0 then hold; o_done=1 from the edge producing 0; en stays high, no change; i_load 4 -> o_cnt=4, o_done=0.
REQ-040 Priority: i_clr, i_load (val 9) and i_en together -> o_cnt=0; i_load with val 50 and i_bnd=20 -> o_cnt=20.
REQ-041 Reset: RST_VAL=3; assert i_rstn=0 mid-count with i_clr=1 and i_load=1 -> o_cnt=3, o_done=0, o_wrap=0 on that edge; with i_bnd changed from 30 to 8 while o_cnt=12, up wrap -> next o_cnt=0.

Source files
------------

// File: rtl/cfgcnt_if.sv
// rtl/cfgcnt_if.sv - control and status bundle for the configurable up/down counter
interface cfgcnt_if #(
  parameter int CNT_W = 6
);
  logic             i_en;
  logic             i_clr;
  logic             i_load;
  logic [CNT_W-1:0] i_load_val;
  logic             i_dir;
  logic [CNT_W-1:0] i_step;
  logic [CNT_W-1:0] i_bnd;
  logic [1:0]       i_mode;
  logic [CNT_W-1:0] o_cnt;
  logic             o_tc;
  logic             o_wrap;
  logic             o_done;

  modport master (
    output i_en, i_clr, i_load, i_load_val, i_dir, i_step, i_bnd, i_mode,
    input  o_cnt, o_tc, o_wrap, o_done
  );

  modport slave (
    input  i_en, i_clr, i_load, i_load_val, i_dir, i_step, i_bnd, i_mode,
    output o_cnt, o_tc, o_wrap, o_done
  );
endinterface

// File: rtl/cfgcnt.sv
// rtl/cfgcnt.sv - bounded up/down counter with wrap, saturate and one-shot modes
module cfgcnt #(
  parameter int          CNT_W   = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  cfgcnt_if.slave    bus
);

  localparam logic [1:0]       MODE_SAT     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [CNT_W-1:0] RST_CNT      = RST_VAL[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [CNT_W:0]   cnt_w, step_w, bnd_w, sum_w;
  logic [CNT_W-1:0] nxt, term;
  logic             nxt_wrap;
  logic             is_wrap, is_oneshot;

  // Enabled-edge candidate; one extra bit keeps cnt+step from overflowing.
  always_comb begin
    cnt_w      = {1'b0, cnt_q};
    step_w     = {1'b0, bus.i_step};
    bnd_w      = {1'b0, bus.i_bnd};
    sum_w      = cnt_w + step_w;
    is_oneshot = (bus.i_mode == MODE_ONESHOT);
    is_wrap    = (bus.i_mode != MODE_SAT) && !is_oneshot;
    nxt        = cnt_q;
    nxt_wrap   = 1'b0;
    if (bus.i_dir) begin
      if (cnt_q < bus.i_bnd) begin
        nxt = (sum_w > bnd_w) ? bus.i_bnd : sum_w[CNT_W-1:0];
      end else if (is_wrap) begin
        nxt      = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt = bus.i_bnd;
      end
    end else begin
      if (cnt_q != '0) begin
        nxt = (cnt_q >= bus.i_step) ? (cnt_q - bus.i_step) : '0;
      end else if (is_wrap) begin
        nxt      = bus.i_bnd;
        nxt_wrap = 1'b1;
      end else begin
        nxt = '0;
      end
    end
    term = bus.i_dir ? bus.i_bnd : '0;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (bus.i_clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (bus.i_load) begin
      cnt_d  = (bus.i_load_val > bus.i_bnd) ? bus.i_bnd : bus.i_load_val;
      done_d = 1'b0;
    end else if (bus.i_en && (bus.i_step != '0) && !done_q) begin
      // A finished one-shot stays frozen until clear, load or reset.
      cnt_d  = nxt;
      wrap_d = nxt_wrap;
      done_d = is_oneshot && (nxt == term);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q  <= RST_CNT;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign bus.o_cnt  = cnt_q;
  assign bus.o_wrap = wrap_q;
  assign bus.o_done = done_q;
  assign bus.o_tc   = bus.i_dir ? (cnt_q == bus.i_bnd) : (cnt_q == '0);

endmodule

// File: tb/tb_cfgcnt.sv
// tb/tb_cfgcnt.sv - self-checking bench for cfgcnt with directed and randomized scenarios
module tb_cfgcnt;
  localparam int CNT_W   = 6;
  localparam int RST_VAL = 3;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;
  int   m_cnt;
  bit   m_wrap;
  bit   m_done;

  cfgcnt_if #(.CNT_W(CNT_W)) bus ();

  cfgcnt #(.CNT_W(CNT_W), .RST_VAL(RST_VAL)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: advances from the counter rules using plain integers.
  task automatic tick();
    int  c, b, s, lv, n;
    bit  w, d, wrapmode;
    c  = m_cnt;
    b  = int'(bus.i_bnd);
    s  = int'(bus.i_step);
    lv = int'(bus.i_load_val);
    w  = 1'b0;
    d  = m_done;
    if (!rstn) begin
      c = RST_VAL; d = 1'b0;
    end else if (bus.i_clr) begin
      c = 0; d = 1'b0;
    end else if (bus.i_load) begin
      c = (lv < b) ? lv : b; d = 1'b0;
    end else if (bus.i_en && s != 0 && !m_done) begin
      wrapmode = (bus.i_mode != 2'b01) && (bus.i_mode != 2'b10);
      if (bus.i_dir) begin
        if (c < b) n = (c + s > b) ? b : c + s;
        else begin n = wrapmode ? 0 : b; w = wrapmode; end
      end else begin
        if (c > 0) n = (c - s < 0) ? 0 : c - s;
        else begin n = wrapmode ? b : 0; w = wrapmode; end
      end
      d = (bus.i_mode == 2'b10) && (n == (bus.i_dir ? b : 0));
      c = n;
    end
    @(posedge clk);
    #1;
    m_cnt  = c;
    m_wrap = w;
    m_done = d;
  endtask

  task automatic set_inputs(bit en, bit dir, int step, int bnd, logic [1:0] mode);
    rstn           = 1'b1;
    bus.i_clr      = 1'b0;
    bus.i_load     = 1'b0;
    bus.i_en       = en;
    bus.i_dir      = dir;
    bus.i_step     = CNT_W'(step);
    bus.i_bnd      = CNT_W'(bnd);
    bus.i_mode     = mode;
  endtask

  task automatic do_load(int val);
    bus.i_load     = 1'b1;
    bus.i_load_val = CNT_W'(val);
    tick();
    bus.i_load     = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(1'b1, 1'b1, 1, 30, 2'b00);
    rstn = 1'b0; bus.i_clr = 1'b1; bus.i_load = 1'b1; bus.i_load_val = 6'd9;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'(RST_VAL) || bus.o_wrap !== 1'b0 || bus.o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state cnt=%0d wrap=%0b done=%0b required cnt=%0d wrap=0 done=0",
               bus.o_cnt, bus.o_wrap, bus.o_done, RST_VAL);
    end
    set_inputs(1'b0, 1'b1, 1, 30, 2'b00);
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'(RST_VAL)) begin
      n_errors++;
      $display("FAIL reset_hold_no_en cnt=%0d required %0d", bus.o_cnt, RST_VAL);
    end
    bus.i_en = 1'b1;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'(RST_VAL + 1)) begin
      n_errors++;
      $display("FAIL reset_first_count cnt=%0d required %0d", bus.o_cnt, RST_VAL + 1);
    end
  endtask

  task automatic test_wrap_up();
    int exp;
    set_inputs(1'b0, 1'b1, 1, 32, 2'b00);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    bus.i_en  = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      tick();
      exp = (i <= 32) ? i : i - 33;
      n_checks++;
      if (bus.o_cnt !== 6'(exp) || bus.o_wrap !== (i == 33) || bus.o_tc !== (exp == 32)) begin
        n_errors++;
        $display("FAIL wrap_up step %0d cnt=%0d wrap=%0b tc=%0b required cnt=%0d wrap=%0b tc=%0b",
                 i, bus.o_cnt, bus.o_wrap, bus.o_tc, exp, (i == 33), (exp == 32));
      end
    end
  endtask

  task automatic test_step_clamp();
    int up_seq[4] = '{4, 8, 10, 0};
    int dn_seq[4] = '{6, 2, 0, 10};
    set_inputs(1'b0, 1'b1, 4, 10, 2'b00);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    bus.i_en  = 1'b1;
    foreach (up_seq[i]) begin
      tick();
      n_checks++;
      if (bus.o_cnt !== 6'(up_seq[i])) begin
        n_errors++;
        $display("FAIL clamp_up[%0d] cnt=%0d required %0d", i, bus.o_cnt, up_seq[i]);
      end
    end
    do_load(10);
    bus.i_dir = 1'b0;
    foreach (dn_seq[i]) begin
      tick();
      n_checks++;
      if (bus.o_cnt !== 6'(dn_seq[i]) || bus.o_wrap !== (i == 3)) begin
        n_errors++;
        $display("FAIL clamp_down[%0d] cnt=%0d wrap=%0b required cnt=%0d wrap=%0b",
                 i, bus.o_cnt, bus.o_wrap, dn_seq[i], (i == 3));
      end
    end
  endtask

  task automatic test_saturate();
    int seq[4] = '{3, 5, 5, 5};
    set_inputs(1'b0, 1'b1, 3, 5, 2'b01);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    bus.i_en  = 1'b1;
    foreach (seq[i]) begin
      tick();
      n_checks++;
      if (bus.o_cnt !== 6'(seq[i]) || bus.o_wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL saturate[%0d] cnt=%0d wrap=%0b required cnt=%0d wrap=0",
                 i, bus.o_cnt, bus.o_wrap, seq[i]);
      end
    end
  endtask

  task automatic test_oneshot_down();
    int seq[7] = '{5, 3, 1, 0, 0, 0, 0};
    set_inputs(1'b0, 1'b0, 2, 20, 2'b10);
    do_load(7);
    bus.i_en = 1'b1;
    foreach (seq[i]) begin
      tick();
      n_checks++;
      if (bus.o_cnt !== 6'(seq[i]) || bus.o_done !== (i >= 3)) begin
        n_errors++;
        $display("FAIL oneshot[%0d] cnt=%0d done=%0b required cnt=%0d done=%0b",
                 i, bus.o_cnt, bus.o_done, seq[i], (i >= 3));
      end
    end
    do_load(4);
    n_checks++;
    if (bus.o_cnt !== 6'd4 || bus.o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL oneshot_reload cnt=%0d done=%0b required cnt=4 done=0", bus.o_cnt, bus.o_done);
    end
  endtask

  task automatic test_priority();
    set_inputs(1'b1, 1'b1, 1, 20, 2'b00);
    bus.i_clr = 1'b1; bus.i_load = 1'b1; bus.i_load_val = 6'd9;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'd0) begin
      n_errors++;
      $display("FAIL prio_clr cnt=%0d required 0", bus.o_cnt);
    end
    bus.i_clr = 1'b0;
    do_load(50);
    n_checks++;
    if (bus.o_cnt !== 6'd20) begin
      n_errors++;
      $display("FAIL prio_load_clamp cnt=%0d required 20", bus.o_cnt);
    end
  endtask

  task automatic test_bnd_lower();
    set_inputs(1'b0, 1'b1, 1, 30, 2'b00);
    do_load(12);
    bus.i_bnd = 6'd8;
    bus.i_en  = 1'b1;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'd0 || bus.o_wrap !== 1'b1) begin
      n_errors++;
      $display("FAIL bnd_lower cnt=%0d wrap=%0b required cnt=0 wrap=1", bus.o_cnt, bus.o_wrap);
    end
    set_inputs(1'b0, 1'b1, 1, 8, 2'b10);
    do_load(6);
    bus.i_en = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'd8 || bus.o_done !== 1'b1) begin
      n_errors++;
      $display("FAIL oneshot_up cnt=%0d done=%0b required cnt=8 done=1", bus.o_cnt, bus.o_done);
    end
    rstn = 1'b0; bus.i_clr = 1'b1; bus.i_load = 1'b1;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'(RST_VAL) || bus.o_done !== 1'b0 || bus.o_wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_done cnt=%0d done=%0b wrap=%0b required cnt=%0d done=0 wrap=0",
               bus.o_cnt, bus.o_done, bus.o_wrap, RST_VAL);
    end
    // Reset on the edge that would otherwise wrap must leave no pulse.
    set_inputs(1'b1, 1'b1, 1, 3, 2'b00);
    rstn = 1'b0;
    tick();
    n_checks++;
    if (bus.o_cnt !== 6'(RST_VAL) || bus.o_wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_at_wrap cnt=%0d wrap=%0b required cnt=%0d wrap=0",
               bus.o_cnt, bus.o_wrap, RST_VAL);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    set_inputs(1'b1, 1'b1, 1, 40, 2'b00);
    for (int i = 0; i < 600; i++) begin
      rstn           = ($urandom_range(0, 99) >= 2);
      bus.i_clr      = ($urandom_range(0, 99) < 4);
      bus.i_load     = ($urandom_range(0, 99) < 7);
      bus.i_load_val = CNT_W'($urandom);
      bus.i_en       = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 4) == 0) bus.i_dir = ~bus.i_dir;
      if ($urandom_range(0, 9) == 0) bus.i_mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) bus.i_bnd = CNT_W'($urandom);
      bus.i_step     = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 5));
      tick();
      n_checks++;
      if (int'(bus.o_cnt) !== m_cnt || bus.o_wrap !== m_wrap || bus.o_done !== m_done ||
          bus.o_tc !== (bus.i_dir ? (m_cnt == int'(bus.i_bnd)) : (m_cnt == 0))) begin
        n_errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] cnt=%0d wrap=%0b done=%0b tc=%0b required cnt=%0d wrap=%0b done=%0b",
                   i, bus.o_cnt, bus.o_wrap, bus.o_done, bus.o_tc, m_cnt, m_wrap, m_done);
        m_cnt  = int'(bus.o_cnt);
        m_wrap = bus.o_wrap;
        m_done = bus.o_done;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_cnt    = 0;
    m_wrap   = 1'b0;
    m_done   = 1'b0;
    bus.i_load_val = '0;
    set_inputs(1'b0, 1'b1, 1, 30, 2'b00);
    #2;
    test_reset();
    test_wrap_up();
    test_step_clamp();
    test_saturate();
    test_oneshot_down();
    test_priority();
    test_bnd_lower();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
